// File: rtl/risc_dof_stage.sv
// Decode/operand-fetch stage: decoder, 32x32 register file, A/B operand muxes
// and the DOF/EX pipeline register. Define DOF_R0_ZERO_EN to hardwire R0 to 0.
module risc_dof_stage (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] PC_1,
  input  logic [31:0] IR,
  input  logic        HA,
  input  logic        HB,
  input  logic [31:0] Bus_Dprime,
  input  logic        branch_predict,
  input  logic        WB_RW,
  input  logic [4:0]  WB_DA,
  input  logic [31:0] Bus_D,
  output logic [15:0] PC_2,
  output logic        RW_reg,
  output logic [4:0]  DA_reg,
  output logic [1:0]  MD_reg,
  output logic [1:0]  BS_reg,
  output logic        PS_reg,
  output logic        MW_reg,
  output logic [4:0]  FS_reg,
  output logic [4:0]  SH_reg,
  output logic        MA,
  output logic        MB,
  output logic [4:0]  AA,
  output logic [4:0]  BA,
  output logic [31:0] Bus_A_reg,
  output logic [31:0] Bus_B_reg
);

  logic [6:0]  opcode;
  logic        rw, ps, mw, mb, ma, cs;
  logic [1:0]  md, bs;
  logic [4:0]  fs;
  logic [31:0] rf [32];
  logic        wr_en;
  logic [31:0] rd_a, rd_b;
  logic [31:0] konst;
  logic [31:0] bus_a, bus_b;

  assign opcode = IR[31:25];
  assign AA     = IR[19:15];
  assign BA     = IR[14:10];
  assign MA     = ma;
  assign MB     = mb;

  // Instruction decoder; unknown opcodes fall through to the NOP word
  always_comb begin
    rw = 1'b0;
    md = 2'b00;
    bs = 2'b00;
    ps = 1'b0;
    mw = 1'b0;
    fs = 5'd0;
    mb = 1'b0;
    ma = 1'b0;
    cs = 1'b0;
    case (opcode)
      7'b1000000: rw = 1'b1;
      7'b0000010: begin rw = 1'b1; fs = 5'b00010; end
      7'b0000101: begin rw = 1'b1; fs = 5'b00101; end
      7'b0001000: begin rw = 1'b1; fs = 5'b01000; end
      7'b0001001: begin rw = 1'b1; fs = 5'b01001; end
      7'b0001010: begin rw = 1'b1; fs = 5'b01010; end
      7'b0001011: begin rw = 1'b1; fs = 5'b01011; end
      7'b0001110: begin rw = 1'b1; fs = 5'b01110; end
      7'b0001101: begin rw = 1'b1; fs = 5'b01101; end
      7'b0100010: begin
        rw = 1'b1; fs = 5'b00010; mb = 1'b1; cs = 1'b1;
      end
      7'b0100101: begin
        rw = 1'b1; fs = 5'b00101; mb = 1'b1; cs = 1'b1;
      end
      7'b0101000: begin rw = 1'b1; fs = 5'b01000; mb = 1'b1; end
      7'b0101001: begin rw = 1'b1; fs = 5'b01001; mb = 1'b1; end
      7'b0010000: begin rw = 1'b1; md = 2'b01; end
      7'b0100000: mw = 1'b1;
      7'b1100101: begin rw = 1'b1; md = 2'b10; fs = 5'b00101; end
      7'b1100000: begin
        bs = 2'b01; ps = 1'b1; mb = 1'b1; cs = 1'b1;
      end
      7'b1001000: begin bs = 2'b01; mb = 1'b1; cs = 1'b1; end
      7'b1000100: begin bs = 2'b11; mb = 1'b1; cs = 1'b1; end
      7'b1110000: bs = 2'b10;
      7'b0000111: begin
        rw = 1'b1; bs = 2'b11; fs = 5'b00111;
        mb = 1'b1; ma = 1'b1; cs = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef DOF_R0_ZERO_EN
  assign wr_en = WB_RW && (WB_DA != 5'd0);
`else
  assign wr_en = WB_RW;
`endif

  // Register file reads with write-through bypass of the writeback port
  always_comb begin
    rd_a = (wr_en && WB_DA == AA) ? Bus_D : rf[AA];
    rd_b = (wr_en && WB_DA == BA) ? Bus_D : rf[BA];
`ifdef DOF_R0_ZERO_EN
    if (AA == 5'd0) rd_a = 32'd0;
    if (BA == 5'd0) rd_b = 32'd0;
`endif
  end

  // Immediate extension and operand muxes (constant/PC beat forwarding)
  always_comb begin
    konst = cs ? {{17{IR[14]}}, IR[14:0]} : {17'd0, IR[14:0]};
    if (ma)      bus_a = {16'd0, PC_1};
    else if (HA) bus_a = Bus_Dprime;
    else         bus_a = rd_a;
    if (mb)      bus_b = konst;
    else if (HB) bus_b = Bus_Dprime;
    else         bus_b = rd_b;
  end

  // Register file storage; reset wins over a same-edge writeback
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (wr_en) begin
      rf[WB_DA] <= Bus_D;
    end
  end

  // DOF/EX pipeline register; a bubble zeroes only the control word
  always_ff @(posedge CLK) begin
    if (reset) begin
      PC_2      <= 16'd0;
      RW_reg    <= 1'b0;
      DA_reg    <= 5'd0;
      MD_reg    <= 2'd0;
      BS_reg    <= 2'd0;
      PS_reg    <= 1'b0;
      MW_reg    <= 1'b0;
      FS_reg    <= 5'd0;
      SH_reg    <= 5'd0;
      Bus_A_reg <= 32'd0;
      Bus_B_reg <= 32'd0;
    end else begin
      PC_2      <= PC_1;
      DA_reg    <= IR[24:20];
      SH_reg    <= IR[4:0];
      Bus_A_reg <= bus_a;
      Bus_B_reg <= bus_b;
      RW_reg    <= rw & branch_predict;
      MD_reg    <= md & {2{branch_predict}};
      BS_reg    <= bs & {2{branch_predict}};
      PS_reg    <= ps & branch_predict;
      MW_reg    <= mw & branch_predict;
      FS_reg    <= fs & {5{branch_predict}};
    end
  end

endmodule

// File: tb/tb_risc_dof_stage.sv
// Testbench for risc_dof_stage: directed scenarios plus randomized
// instructions checked against a table-driven model of the stage.
module tb_risc_dof_stage;

  logic        CLK = 1'b0;
  logic        reset;
  logic [15:0] PC_1;
  logic [31:0] IR;
  logic        HA, HB;
  logic [31:0] Bus_Dprime;
  logic        branch_predict;
  logic        WB_RW;
  logic [4:0]  WB_DA;
  logic [31:0] Bus_D;
  logic [15:0] PC_2;
  logic        RW_reg;
  logic [4:0]  DA_reg;
  logic [1:0]  MD_reg, BS_reg;
  logic        PS_reg, MW_reg;
  logic [4:0]  FS_reg, SH_reg;
  logic        MA, MB;
  logic [4:0]  AA, BA;
  logic [31:0] Bus_A_reg, Bus_B_reg;

  int total = 0;
  int bad = 0;

  // control word table: {RW,MD,BS,PS,MW,FS,MB,MA,CS}
  logic [14:0] dec [128];
  logic [6:0]  ops [$];
  logic [31:0] mrf [32];

  risc_dof_stage dut (
    .CLK(CLK), .reset(reset), .PC_1(PC_1), .IR(IR),
    .HA(HA), .HB(HB), .Bus_Dprime(Bus_Dprime),
    .branch_predict(branch_predict),
    .WB_RW(WB_RW), .WB_DA(WB_DA), .Bus_D(Bus_D),
    .PC_2(PC_2), .RW_reg(RW_reg), .DA_reg(DA_reg),
    .MD_reg(MD_reg), .BS_reg(BS_reg), .PS_reg(PS_reg),
    .MW_reg(MW_reg), .FS_reg(FS_reg), .SH_reg(SH_reg),
    .MA(MA), .MB(MB), .AA(AA), .BA(BA),
    .Bus_A_reg(Bus_A_reg), .Bus_B_reg(Bus_B_reg)
  );

  always #5 CLK = ~CLK;

  task automatic add_op(input logic [6:0] op, input logic [14:0] w);
    dec[op] = w;
    ops.push_back(op);
  endtask

  task automatic init_table();
    for (int i = 0; i < 128; i++) dec[i] = 15'd0;
    add_op(7'b0000000, 15'b0_00_00_0_0_00000_0_0_0);
    add_op(7'b1000000, 15'b1_00_00_0_0_00000_0_0_0);
    add_op(7'b0000010, 15'b1_00_00_0_0_00010_0_0_0);
    add_op(7'b0000101, 15'b1_00_00_0_0_00101_0_0_0);
    add_op(7'b0001000, 15'b1_00_00_0_0_01000_0_0_0);
    add_op(7'b0001001, 15'b1_00_00_0_0_01001_0_0_0);
    add_op(7'b0001010, 15'b1_00_00_0_0_01010_0_0_0);
    add_op(7'b0001011, 15'b1_00_00_0_0_01011_0_0_0);
    add_op(7'b0001110, 15'b1_00_00_0_0_01110_0_0_0);
    add_op(7'b0001101, 15'b1_00_00_0_0_01101_0_0_0);
    add_op(7'b0100010, 15'b1_00_00_0_0_00010_1_0_1);
    add_op(7'b0100101, 15'b1_00_00_0_0_00101_1_0_1);
    add_op(7'b0101000, 15'b1_00_00_0_0_01000_1_0_0);
    add_op(7'b0101001, 15'b1_00_00_0_0_01001_1_0_0);
    add_op(7'b0010000, 15'b1_01_00_0_0_00000_0_0_0);
    add_op(7'b0100000, 15'b0_00_00_0_1_00000_0_0_0);
    add_op(7'b1100101, 15'b1_10_00_0_0_00101_0_0_0);
    add_op(7'b1100000, 15'b0_00_01_1_0_00000_1_0_1);
    add_op(7'b1001000, 15'b0_00_01_0_0_00000_1_0_1);
    add_op(7'b1000100, 15'b0_00_11_0_0_00000_1_0_1);
    add_op(7'b1110000, 15'b0_00_10_0_0_00000_0_0_0);
    add_op(7'b0000111, 15'b1_00_11_0_0_00111_1_1_1);
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
`ifdef DOF_R0_ZERO_EN
    if (a == 5'd0) return 32'd0;
`endif
    if (WB_RW && WB_DA == a) return Bus_D;
    return mrf[a];
  endfunction

  function automatic void mwrite();
`ifdef DOF_R0_ZERO_EN
    if (WB_DA == 5'd0) return;
`endif
    if (WB_RW) mrf[WB_DA] = Bus_D;
  endfunction

  task automatic tick();
    mwrite();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op,
    input logic [4:0] d, input logic [4:0] a, input logic [14:0] im);
    return {op, d, a, im};
  endfunction

  task automatic idle();
    IR = 32'd0; HA = 0; HB = 0; WB_RW = 0;
    branch_predict = 1; PC_1 = 16'd0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    WB_RW = 1; WB_DA = a; Bus_D = d;
    tick();
    WB_RW = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle(); WB_DA = 0; Bus_D = 0; Bus_Dprime = 0;
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    @(posedge CLK); #1;
    total++;
    if ({PC_2, RW_reg, DA_reg, MD_reg, BS_reg, PS_reg, MW_reg,
         FS_reg, SH_reg, Bus_A_reg, Bus_B_reg} !== 102'd0) begin
      bad++;
      $display("FAIL reset_regs got pc=%h a=%h b=%h want 0",
               PC_2, Bus_A_reg, Bus_B_reg);
    end
    reset = 0;
    IR = mk(7'b0000010, 5'd1, 5'd6, {5'd7, 10'd0});
    tick();
    total++;
    if (Bus_A_reg !== 0 || Bus_B_reg !== 0 || RW_reg !== 1) begin
      bad++;
      $display("FAIL reset_rf got a=%h b=%h rw=%b want 0 0 1",
               Bus_A_reg, Bus_B_reg, RW_reg);
    end
  endtask

  task automatic test_add();
    idle();
    wb_write(5'd2, 32'd5);
    wb_write(5'd3, 32'd7);
    IR = mk(7'b0000010, 5'd1, 5'd2, {5'd3, 10'd0});
    PC_1 = 16'd1;
    #1;
    total++;
    if (AA !== 5'd2 || BA !== 5'd3 || MA !== 0 || MB !== 0) begin
      bad++;
      $display("FAIL add_comb got aa=%0d ba=%0d ma=%b mb=%b want 2 3 0 0",
               AA, BA, MA, MB);
    end
    tick();
    total++;
    if (FS_reg !== 5'b00010 || RW_reg !== 1 || DA_reg !== 5'd1 ||
        PC_2 !== 16'd1) begin
      bad++;
      $display("FAIL add_ctrl got fs=%b rw=%b da=%0d pc=%0d want 00010 1 1 1",
               FS_reg, RW_reg, DA_reg, PC_2);
    end
    total++;
    if (Bus_A_reg !== 32'd5 || Bus_B_reg !== 32'd7) begin
      bad++;
      $display("FAIL add_ops got a=%0d b=%0d want 5 7",
               Bus_A_reg, Bus_B_reg);
    end
  endtask

  task automatic test_immediate();
    idle();
    IR = mk(7'b0100010, 5'd1, 5'd2, 15'd1);
    PC_1 = 16'd2;
    #1;
    total++;
    if (MB !== 1'b1) begin
      bad++;
      $display("FAIL adi_mb got %b want 1", MB);
    end
    tick();
    total++;
    if (Bus_A_reg !== 32'd5 || Bus_B_reg !== 32'd1) begin
      bad++;
      $display("FAIL adi_ops got a=%h b=%h want 5 1",
               Bus_A_reg, Bus_B_reg);
    end
    IR = mk(7'b0100010, 5'd1, 5'd2, 15'h7FFF);
    tick();
    total++;
    if (Bus_B_reg !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL adi_sext got %h want ffffffff", Bus_B_reg);
    end
    IR = mk(7'b0101000, 5'd1, 5'd2, 15'h7FFF);
    tick();
    total++;
    if (Bus_B_reg !== 32'h0000_7FFF) begin
      bad++;
      $display("FAIL ani_zext got %h want 00007fff", Bus_B_reg);
    end
  endtask

  task automatic test_forward();
    idle();
    HA = 1; HB = 1; Bus_Dprime = 32'hDEADBEEF;
    IR = mk(7'b0000010, 5'd1, 5'd2, {5'd3, 10'd0});
    tick();
    total++;
    if (Bus_A_reg !== 32'hDEADBEEF || Bus_B_reg !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL fwd got a=%h b=%h want deadbeef deadbeef",
               Bus_A_reg, Bus_B_reg);
    end
    IR = mk(7'b0000111, 5'd4, 5'd2, 15'h4000);
    PC_1 = 16'hBEEF;
    #1;
    total++;
    if (MA !== 1 || MB !== 1) begin
      bad++;
      $display("FAIL jml_sel got ma=%b mb=%b want 1 1", MA, MB);
    end
    tick();
    total++;
    if (Bus_A_reg !== 32'h0000BEEF || Bus_B_reg !== 32'hFFFFC000 ||
        BS_reg !== 2'b11 || FS_reg !== 5'b00111) begin
      bad++;
      $display("FAIL jml_prio got a=%h b=%h bs=%b fs=%b want 0000beef ffffc000 11 00111",
               Bus_A_reg, Bus_B_reg, BS_reg, FS_reg);
    end
    HA = 0; HB = 0;
  endtask

  task automatic test_bubble();
    idle();
    branch_predict = 0; PC_1 = 16'h55;
    IR = mk(7'b0000010, 5'd9, 5'd2, {5'd3, 10'd5});
    tick();
    total++;
    if (RW_reg !== 0 || MW_reg !== 0 || FS_reg !== 0 ||
        DA_reg !== 5'd9 || PC_2 !== 16'h55 || SH_reg !== 5'd5 ||
        Bus_A_reg !== 32'd5) begin
      bad++;
      $display("FAIL bubble got rw=%b mw=%b fs=%b da=%0d pc=%h sh=%0d a=%0d",
               RW_reg, MW_reg, FS_reg, DA_reg, PC_2, SH_reg, Bus_A_reg);
    end
    IR = mk(7'b1100000, 5'd0, 5'd0, 15'd0);
    tick();
    total++;
    if (BS_reg !== 0 || PS_reg !== 0) begin
      bad++;
      $display("FAIL bubble_bz got bs=%b ps=%b want 00 0", BS_reg, PS_reg);
    end
    branch_predict = 1;
    IR = mk(7'b1111111, 5'd3, 5'd2, 15'd0);
    tick();
    total++;
    if ({RW_reg, MD_reg, BS_reg, PS_reg, MW_reg, FS_reg} !== 12'd0) begin
      bad++;
      $display("FAIL bad_op got rw=%b md=%b bs=%b fs=%b want NOP",
               RW_reg, MD_reg, BS_reg, FS_reg);
    end
  endtask

  task automatic test_bypass();
    idle();
    IR = mk(7'b0000010, 5'd1, 5'd2, {5'd2, 10'd0});
    WB_RW = 1; WB_DA = 5'd2; Bus_D = 32'd9;
    tick();
    WB_RW = 0;
    total++;
    if (Bus_A_reg !== 32'd9 || Bus_B_reg !== 32'd9) begin
      bad++;
      $display("FAIL bypass got a=%0d b=%0d want 9 9",
               Bus_A_reg, Bus_B_reg);
    end
  endtask

  task automatic test_random();
    logic [14:0]  w;
    logic [31:0]  ea, eb, k;
    logic [101:0] exp_r, got_r;
    logic [6:0]   op;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) != 0)
        op = ops[$urandom_range(ops.size() - 1)];
      else
        op = 7'($urandom);
      IR = {op, 25'($urandom)};
      PC_1 = 16'($urandom);
      HA = ($urandom_range(3) == 0);
      HB = ($urandom_range(3) == 0);
      Bus_Dprime = $urandom;
      branch_predict = ($urandom_range(4) != 0);
      WB_RW = $urandom_range(1);
      WB_DA = 5'($urandom);
      Bus_D = $urandom;
      #1;
      w = dec[op];
      k = w[0] ? 32'($signed(IR[14:0])) : 32'(IR[14:0]);
      ea = w[1] ? {16'd0, PC_1} : HA ? Bus_Dprime : mread(IR[19:15]);
      eb = w[2] ? k : HB ? Bus_Dprime : mread(IR[14:10]);
      total++;
      if ({MA, MB, AA, BA} !== {w[1], w[2], IR[19:15], IR[14:10]}) begin
        bad++;
        $display("FAIL rnd_comb n=%0d got %b want %b", n,
                 {MA, MB, AA, BA}, {w[1], w[2], IR[19:15], IR[14:10]});
      end
      if (!branch_predict) w = 15'd0;
      exp_r = {PC_1, w[14], IR[24:20], w[13:12], w[11:10], w[9],
               w[8], w[7:3], IR[4:0], ea, eb};
      tick();
      got_r = {PC_2, RW_reg, DA_reg, MD_reg, BS_reg, PS_reg,
               MW_reg, FS_reg, SH_reg, Bus_A_reg, Bus_B_reg};
      total++;
      if (got_r !== exp_r) begin
        bad++;
        $display("FAIL rnd_regs n=%0d got %h want %h", n, got_r, exp_r);
      end
    end
    idle();
  endtask

  task automatic test_reset_priority();
    idle();
    reset = 1; WB_RW = 1; WB_DA = 5'd4; Bus_D = 32'h1234;
    @(posedge CLK); #1;
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    reset = 0; WB_RW = 0;
    total++;
    if (PC_2 !== 0 || Bus_A_reg !== 0 || RW_reg !== 0) begin
      bad++;
      $display("FAIL rst_mid got pc=%h a=%h rw=%b want 0",
               PC_2, Bus_A_reg, RW_reg);
    end
    IR = mk(7'b0000010, 5'd1, 5'd4, {5'd2, 10'd0});
    tick();
    total++;
    if (Bus_A_reg !== 0 || Bus_B_reg !== 0) begin
      bad++;
      $display("FAIL rst_prio got a=%h b=%h want 0 0",
               Bus_A_reg, Bus_B_reg);
    end
  endtask

  task automatic test_r0();
    logic [31:0] want;
`ifdef DOF_R0_ZERO_EN
    want = 32'd0;
`else
    want = 32'd9;
`endif
    idle();
    wb_write(5'd0, 32'd9);
    IR = mk(7'b0000010, 5'd1, 5'd0, {5'd0, 10'd0});
    tick();
    total++;
    if (Bus_A_reg !== want || Bus_B_reg !== want) begin
      bad++;
      $display("FAIL r0 got a=%0d b=%0d want %0d",
               Bus_A_reg, Bus_B_reg, want);
    end
    IR = mk(7'b0000010, 5'd1, 5'd0, {5'd0, 10'd0});
    WB_RW = 1; WB_DA = 5'd0; Bus_D = 32'd77;
`ifdef DOF_R0_ZERO_EN
    want = 32'd0;
`else
    want = 32'd77;
`endif
    tick();
    WB_RW = 0;
    total++;
    if (Bus_A_reg !== want) begin
      bad++;
      $display("FAIL r0_bypass got a=%0d want %0d", Bus_A_reg, want);
    end
  endtask

  initial begin
    init_table();
    test_reset();
    test_add();
    test_immediate();
    test_forward();
    test_bubble();
    test_bypass();
    test_random();
    test_reset_priority();
    test_r0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
